// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus a stability-qualifying FSM for a raw button level.
// Optional toggle_q output is built only when DEBOUNCE_TOGGLE_EN is defined.
module button_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_level,
    output logic rise_pulse,
`ifdef DEBOUNCE_TOGGLE_EN
    output logic fall_pulse,
    output logic toggle_q
`else
    output logic fall_pulse
`endif
);

    // state     | meaning
    // IDLE_LOW  | accepted level is 0, watching for s2=1
    // WAIT_HIGH | s2 went high, counting stable cycles before accepting 1
    // IDLE_HIGH | accepted level is 1, watching for s2=0
    // WAIT_LOW  | s2 went low, counting stable cycles before accepting 0
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            btn_level  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (s2) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state      <= IDLE_HIGH;
                        btn_level  <= 1'b1;
                        rise_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!s2) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s2) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state      <= IDLE_LOW;
                        btn_level  <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_TOGGLE_EN
    // Flips on the same edge that raises rise_pulse, so it tracks accepted presses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= 1'b0;
        end else if (state == WAIT_HIGH && s2 && cnt == CNT_MAX) begin
            toggle_q <= ~toggle_q;
        end
    end
`endif

endmodule
